// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack: {push,pop} op codes
// and the count-width helper.
package stack_pkg;

  // {push, pop} decode of a request
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Bits needed to hold an occupancy of 0..depth inclusive
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// combinational read port. Contents are not reset; the stack masks
// unwritten entries through its occupancy count.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: addresses beyond DEPTH (non power-of-two depths) are dropped
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: out-of-range addresses read as zero rather than X
  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack. The only architectural state is the occupancy
// count; the top entry lives at mem[count-1]. Supports push, pop,
// replace-top (push+pop), synchronous clear, and overflow/underflow
// pulses folded into a sticky error flag.
module param_stack
  import stack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int CW    = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             err_q, err_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] rd_data;
  logic             empty_w;
  logic             full_w;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == DEPTH_C);
  // Wraps when empty; the read result is masked in that case
  assign top_addr = AW'(count_q - CW'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_i),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  // Next-state decode: clear first, then the {push,pop} operation
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = AW'(count_q);
    if (en) begin
      if (clr) begin
        count_d = '0;
        err_d   = 1'b0;
      end else begin
        case ({push, pop})
          OP_PUSH: begin
            if (!full_w) begin
              we      = 1'b1;
              waddr   = AW'(count_q);
              count_d = count_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
              err_d = 1'b1;
            end
          end
          OP_POP: begin
            if (!empty_w) begin
              count_d = count_q - CW'(1);
            end else begin
              unf_d = 1'b1;
              err_d = 1'b1;
            end
          end
          OP_REPL: begin
            we = 1'b1;
            if (!empty_w) begin
              // Replace-top is legal even when full
              waddr = top_addr;
            end else begin
              // The pop half underflows but the push half still lands
              waddr   = '0;
              count_d = CW'(1);
              unf_d   = 1'b1;
              err_d   = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Count and error state; async active-low reset returns to empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      err_q   <= err_d;
    end
  end

  assign data_o = empty_w ? '0 : rd_data;
  assign count  = count_q;
  assign empty  = empty_w;
  assign full   = full_w;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: a DEPTH=4/WIDTH=8 and a DEPTH=5/WIDTH=16 instance
// driven by the same inputs, each tracked by a queue-based LIFO model.
module tb_param_stack;

  localparam int DA = 4;
  localparam int DB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en   = 1'b0;
  logic        clr  = 1'b0;
  logic        push = 1'b0;
  logic        pop  = 1'b0;
  logic [15:0] din  = '0;

  logic [7:0]  data_a;
  logic [2:0]  cnt_a;
  logic        empty_a, full_a, ovf_a, unf_a, err_a;
  logic [15:0] data_b;
  logic [2:0]  cnt_b;
  logic        empty_b, full_b, ovf_b, unf_b, err_b;

  param_stack #(.WIDTH(8), .DEPTH(DA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .push(push), .pop(pop),
    .data_i(din[7:0]), .data_o(data_a), .count(cnt_a), .empty(empty_a),
    .full(full_a), .ovf(ovf_a), .unf(unf_a), .err(err_a)
  );

  param_stack #(.WIDTH(16), .DEPTH(DB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .push(push), .pop(pop),
    .data_i(din), .data_o(data_b), .count(cnt_b), .empty(empty_b),
    .full(full_b), .ovf(ovf_b), .unf(unf_b), .err(err_b)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] stk_a[$];
  logic [15:0] stk_b[$];
  logic        m_err_a = 1'b0, m_ovf_a = 1'b0, m_unf_a = 1'b0;
  logic        m_err_b = 1'b0, m_ovf_b = 1'b0, m_unf_b = 1'b0;

  // One clock edge of a LIFO with saturating occupancy
  task automatic model_step(input int which);
    logic [15:0] s[$];
    logic [15:0] dv;
    int          depth;
    logic        e, o, u;
    if (which == 0) begin
      s = stk_a; depth = DA; e = m_err_a; dv = {8'h00, din[7:0]};
    end else begin
      s = stk_b; depth = DB; e = m_err_b; dv = din;
    end
    o = 1'b0;
    u = 1'b0;
    if (en) begin
      if (clr) begin
        s.delete();
        e = 1'b0;
      end else if (push && !pop) begin
        if (s.size() < depth) s.push_back(dv);
        else o = 1'b1;
      end else if (pop && !push) begin
        if (s.size() > 0) void'(s.pop_back());
        else u = 1'b1;
      end else if (push && pop) begin
        if (s.size() > 0) s[s.size()-1] = dv;
        else begin
          s.push_back(dv);
          u = 1'b1;
        end
      end
    end
    e = e | o | u;
    if (which == 0) begin
      stk_a = s; m_err_a = e; m_ovf_a = o; m_unf_a = u;
    end else begin
      stk_b = s; m_err_b = e; m_ovf_b = o; m_unf_b = u;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_a.delete(); m_err_a = 1'b0; m_ovf_a = 1'b0; m_unf_a = 1'b0;
      stk_b.delete(); m_err_b = 1'b0; m_ovf_b = 1'b0; m_unf_b = 1'b0;
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_count", 32'(cnt_a), 32'(stk_a.size()));
      check("a_data", 32'(data_a), (stk_a.size() > 0) ? 32'(stk_a[stk_a.size()-1]) : 32'h0);
      check("a_empty", 32'(empty_a), 32'(stk_a.size() == 0));
      check("a_full", 32'(full_a), 32'(stk_a.size() == DA));
      check("a_ovf", 32'(ovf_a), 32'(m_ovf_a));
      check("a_unf", 32'(unf_a), 32'(m_unf_a));
      check("a_err", 32'(err_a), 32'(m_err_a));
      check("b_count", 32'(cnt_b), 32'(stk_b.size()));
      check("b_data", 32'(data_b), (stk_b.size() > 0) ? 32'(stk_b[stk_b.size()-1]) : 32'h0);
      check("b_empty", 32'(empty_b), 32'(stk_b.size() == 0));
      check("b_full", 32'(full_b), 32'(stk_b.size() == DB));
      check("b_ovf", 32'(ovf_b), 32'(m_ovf_b));
      check("b_unf", 32'(unf_b), 32'(m_unf_b));
      check("b_err", 32'(err_b), 32'(m_err_b));
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one operation for one clock edge, then return to idle 2 time
  // units after the edge so outputs can be sampled.
  task automatic op(input logic e, input logic c, input logic pu, input logic po, input logic [15:0] d);
    en = e; clr = c; push = pu; pop = po; din = d;
    @(posedge clk);
    #2;
    en = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
  endtask

  task automatic do_push(input logic [15:0] d); op(1'b1, 1'b0, 1'b1, 1'b0, d); endtask
  task automatic do_pop();                      op(1'b1, 1'b0, 1'b0, 1'b1, '0); endtask
  task automatic do_clr();                      op(1'b1, 1'b1, 1'b0, 1'b0, '0); endtask
  task automatic do_idle();                     op(1'b1, 1'b0, 1'b0, 1'b0, '0); endtask

  logic [7:0] pushed [4];
  logic [7:0] pop_exp [4];
  int         n_ovf_a, n_ovf_b;

  initial begin
    pushed  = '{8'h11, 8'h22, 8'h33, 8'h44};
    pop_exp = '{8'h33, 8'h22, 8'h11, 8'h00};

    // 1. reset, idle, then asynchronous reset mid-stream
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    chk_en = 1'b1;
    en = 1'b1;
    do_idle();
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_data", 32'(data_a), 32'h00);
    check("rst_err", 32'(err_a), 32'd0);
    do_push(16'h0011);
    do_push(16'h0022);
    check("pre_rst_count", 32'(cnt_a), 32'd2);
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(cnt_a), 32'd0);
    check("async_rst_data", 32'(data_a), 32'h00);
    check("async_rst_empty", 32'(empty_a), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // 2. fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      do_push({8'h00, pushed[i]});
      check("fill_count", 32'(cnt_a), 32'(i + 1));
      check("fill_data", 32'(data_a), 32'(pushed[i]));
    end
    check("fill_full", 32'(full_a), 32'd1);
    do_push(16'h0055);
    check("ovf_pulse", 32'(ovf_a), 32'd1);
    check("ovf_err", 32'(err_a), 32'd1);
    check("ovf_data", 32'(data_a), 32'h44);
    check("ovf_count", 32'(cnt_a), 32'd4);
    do_idle();
    check("ovf_clears", 32'(ovf_a), 32'd0);
    check("err_sticky", 32'(err_a), 32'd1);

    // 3. drain, then underflow
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check("drain_data", 32'(data_a), 32'(pop_exp[i]));
    end
    check("drain_empty", 32'(empty_a), 32'd1);
    do_pop();
    check("unf_pulse", 32'(unf_a), 32'd1);
    check("unf_count", 32'(cnt_a), 32'd0);

    // 4. replace-top, including while full
    do_clr();
    do_push(16'h00A1);
    do_push(16'h00A2);
    op(1'b1, 1'b0, 1'b1, 1'b1, 16'h00B7);
    check("repl_count", 32'(cnt_a), 32'd2);
    check("repl_data", 32'(data_a), 32'hB7);
    check("repl_ovf", 32'(ovf_a), 32'd0);
    check("repl_unf", 32'(unf_a), 32'd0);
    do_push(16'h0003);
    do_push(16'h0004);
    op(1'b1, 1'b0, 1'b1, 1'b1, 16'h00C8);
    check("repl_full_data", 32'(data_a), 32'hC8);
    check("repl_full_count", 32'(cnt_a), 32'd4);
    check("repl_full_ovf", 32'(ovf_a), 32'd0);
    do_pop();
    check("repl_below", 32'(data_a), 32'h03);

    // 5. push+pop on empty, clear priority, enable gating
    do_clr();
    op(1'b1, 1'b0, 1'b1, 1'b1, 16'h005C);
    check("pp_empty_count", 32'(cnt_a), 32'd1);
    check("pp_empty_data", 32'(data_a), 32'h5C);
    check("pp_empty_unf", 32'(unf_a), 32'd1);
    check("pp_empty_err", 32'(err_a), 32'd1);
    op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0066);
    check("clr_count", 32'(cnt_a), 32'd0);
    check("clr_err", 32'(err_a), 32'd0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 16'h0077);
    check("en0_count", 32'(cnt_a), 32'd0);
    check("en0_empty", 32'(empty_a), 32'd1);

    // 6. saturation on the DEPTH=5 instance
    do_clr();
    n_ovf_a = 0;
    n_ovf_b = 0;
    for (int i = 0; i < 6; i++) begin
      do_push(16'h1000 + 16'(i));
      if (ovf_a) n_ovf_a++;
      if (ovf_b) n_ovf_b++;
    end
    do_idle();
    if (ovf_a) n_ovf_a++;
    if (ovf_b) n_ovf_b++;
    check("sat_b_count", 32'(cnt_b), 32'd5);
    check("sat_b_data", 32'(data_b), 32'h1004);
    check("sat_b_ovf_pulses", 32'(n_ovf_b), 32'd1);
    check("sat_a_ovf_pulses", 32'(n_ovf_a), 32'd2);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      else rst = 1'b1;
      op(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end
    rst = 1'b1;
    do_idle();
    do_idle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack for the CPU datapath: call/return address stack and operand stack.
- Successor to the fixed 32×8 stack. Width and depth are generic.
- Adds simultaneous push+pop (replace-top), an occupancy count, full/empty flags, overflow/underflow error reporting with a sticky error, and synchronous clear.
- Pointer-addressed register array. No per-entry tri-state; output mux is combinational from the top entry.

Parameters:
WIDTH, 8, data bits per entry
DEPTH, 32, number of entries (≥2, any integer, not limited to power of 2)
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  operation enable; push/pop/clr ignored when 0
clr  in  1  synchronous clear (empties stack, clears sticky error); priority over push/pop
push  in  1  push request
pop  in  1  pop request
data_i  in  WIDTH  push data
data_o  out  WIDTH  current top-of-stack; 0 when empty
count  out  CW  entries held, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
ovf  out  1  one-cycle pulse: push rejected
unf  out  1  one-cycle pulse: pop rejected
err  out  1  sticky OR of ovf/unf since last clr/reset

Behaviour:
- Reset (rst=0, async): count=0, err=0, ovf=0, unf=0, empty=1, full=0. Storage contents need not be reset, but data_o must read 0 because the stack is empty.
- State is count (sp). Top entry is mem[count-1].
- data_o, empty and full are combinational from count/mem: zero-latency peek.
- A pushed value appears on data_o the cycle after the push edge.
- Each rising clk with en=1 is decided by priority:
  1. clr=1 → count=0, err=0, ovf=unf=0; push/pop ignored.
  2. push & !pop, !full → mem[count]=data_i, count+1.
  3. push & !pop, full → no change, ovf=1 for one cycle, err=1.
  4. pop & !push, !empty → count-1. Popped entry's storage is not cleared.
  5. pop & !push, empty → no change, unf=1, err=1.
  6. push & pop, !empty → replace top: mem[count-1]=data_i, count unchanged. Legal even when full (no ovf).
  7. push & pop, empty → push executes (mem[0]=data_i, count=1), unf=1, err=1.
  8. neither → hold.
- en=0: no state change; ovf/unf deassert the next cycle; err holds.
- ovf/unf are registered. They are high exactly the cycle after the offending edge and low otherwise.
- Wrap-around: none. count saturates at DEPTH and 0 through the rejection rules above. Pointer arithmetic is never modulo.
- Reset mid-operation: asynchronous entry to the empty state. The first edge after rst deasserts behaves as on an empty stack.
- No X on outputs at any time after reset.

Decomposition:
- Shared package stack_pkg:
  - op-decode constants OP_NONE/OP_PUSH/OP_POP/OP_REPL, a 2-bit {push,pop} encoding;
  - a function computing CW from DEPTH.
- One sub-module, stack_regfile: DEPTH×WIDTH register array with one synchronous write port (addr, data, we) and one combinational read port.
- param_stack holds count, the flag logic and the error logic.

Test Plan (WIDTH=8, DEPTH=4 unless stated):
1. Reset then idle → count=0, empty=1, full=0, data_o=0x00, err=0; apply rst=0 mid-stream after 2 pushes → count=0, data_o=0 immediately, without waiting for an edge.
2. Push 0x11,0x22,0x33,0x44 → count 1..4, data_o follows 0x11→0x44, full=1. Push 0x55 → ovf pulse one cycle, err=1, data_o stays 0x44, count=4.
3. From full, pop ×4 → data_o 0x33,0x22,0x11,0x00, empty=1. Pop again → unf pulse, count stays 0.
4. With 0xA1,0xA2 stacked, push&pop with data_i=0xB7 → count=2, data_o=0xB7, no ovf/unf. Repeat while full → top replaced, no ovf.
5. Empty, push&pop with data_i=0x5C → count=1, data_o=0x5C, unf=1 one cycle, err=1. Then clr=1 with push=1 → count=0, err=0, push ignored. Then en=0 with push=1 → no change.
6. DEPTH=5, WIDTH=16: push 6 values → count saturates at 5, single ovf. Random push/pop for 1000 cycles checked against a reference model (count, data_o, flags).
